// File: rtl/ram.sv
// Single-port synchronous RAM with a registered, zero-when-idle read port.
// Reset clears the whole array in one cycle so the controller starts from known contents.
module ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_p1;

  // stage p0 -> p1: access decode, storage update and read register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dout_p1 <= '0;
    end else begin
      dout_p1 <= '0;
      if (cen && wen) begin
        mem[addr] <= din;
      end else if (cen) begin
        dout_p1 <= mem[addr];
      end
    end
  end

  assign dout = dout_p1;

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed scenarios plus a randomized run against an array model.
module tb_ram;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        wen;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  int checks;
  int passed;

  logic [31:0] model_mem [256];
  logic [31:0] model_dout;

  ram #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .wen  (wen),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what one clock edge does to the storage and the visible read word.
  task automatic model_step(input logic r, input logic c, input logic w,
                            input logic [7:0] a, input logic [31:0] d);
    if (r) begin
      for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
      model_dout = 32'h0;
    end else if (!c) begin
      model_dout = 32'h0;
    end else if (w) begin
      model_mem[a] = d;
      model_dout = 32'h0;
    end else begin
      model_dout = model_mem[a];
    end
  endtask

  // Present one cycle of inputs, clock it, and settle 1 time unit past the edge.
  task automatic cycle(input logic r, input logic c, input logic w,
                       input logic [7:0] a, input logic [31:0] d);
    rst  = r;
    cen  = c;
    wen  = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    model_step(r, c, w, a, d);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    checks++;
    if (dout !== 32'h0) $display("FAIL reset_dout actual=%h required=%h", dout, 32'h0);
    else passed++;
    for (int a = 0; a < 256; a++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'(a), 32'h0);
      checks++;
      if (dout !== 32'h0) $display("FAIL reset_read[%0d] actual=%h required=%h", a, dout, 32'h0);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    for (int a = 0; a < 32; a++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'(a), 32'(a));
      checks++;
      if (dout !== 32'h0) $display("FAIL write_dout[%0d] actual=%h required=%h", a, dout, 32'h0);
      else passed++;
    end
    for (int a = 0; a < 32; a++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'(a), 32'hFFFF_FFFF);
      checks++;
      if (dout !== 32'(a)) $display("FAIL stream_read[%0d] actual=%h required=%h", a, dout, 32'(a));
      else passed++;
    end
  endtask

  task automatic test_cen_drop();
    cycle(1'b0, 1'b1, 1'b0, 8'h04, 32'h0);
    checks++;
    if (dout !== 32'h4) $display("FAIL cen_pre_read actual=%h required=%h", dout, 32'h4);
    else passed++;
    cycle(1'b0, 1'b0, 1'b0, 8'h05, 32'h0);
    checks++;
    if (dout !== 32'h0) $display("FAIL cen_idle actual=%h required=%h", dout, 32'h0);
    else passed++;
    cycle(1'b0, 1'b0, 1'b1, 8'h05, 32'hBAD0_BAD0);
    checks++;
    if (dout !== 32'h0) $display("FAIL cen_idle_wen actual=%h required=%h", dout, 32'h0);
    else passed++;
    cycle(1'b0, 1'b1, 1'b0, 8'h05, 32'h0);
    checks++;
    if (dout !== 32'h5) $display("FAIL cen_resume actual=%h required=%h", dout, 32'h5);
    else passed++;
  endtask

  task automatic test_boundary();
    cycle(1'b0, 1'b1, 1'b1, 8'hFF, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 32'h1234_5678);
    cycle(1'b0, 1'b1, 1'b0, 8'hFF, 32'h0);
    checks++;
    if (dout !== 32'hDEAD_BEEF) $display("FAIL addr_ff actual=%h required=%h", dout, 32'hDEAD_BEEF);
    else passed++;
    // Hold dout between edges: sample again mid-cycle
    #3;
    checks++;
    if (dout !== 32'hDEAD_BEEF) $display("FAIL addr_ff_hold actual=%h required=%h", dout, 32'hDEAD_BEEF);
    else passed++;
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    checks++;
    if (dout !== 32'h1234_5678) $display("FAIL addr_00 actual=%h required=%h", dout, 32'h1234_5678);
    else passed++;
    cycle(1'b0, 1'b1, 1'b0, 8'h7F, 32'h0);
    checks++;
    if (dout !== 32'h0) $display("FAIL addr_7f actual=%h required=%h", dout, 32'h0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 1'b1, 8'h10, 32'hA5A5_A5A5);
    checks++;
    if (dout !== 32'h0) $display("FAIL b2b_write actual=%h required=%h", dout, 32'h0);
    else passed++;
    cycle(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
    checks++;
    if (dout !== 32'hA5A5_A5A5) $display("FAIL b2b_read actual=%h required=%h", dout, 32'hA5A5_A5A5);
    else passed++;
  endtask

  task automatic test_reset_during_write();
    cycle(1'b0, 1'b1, 1'b0, 8'h03, 32'h0);
    checks++;
    if (dout !== 32'h3) $display("FAIL rstw_pre actual=%h required=%h", dout, 32'h3);
    else passed++;
    cycle(1'b1, 1'b1, 1'b1, 8'h03, 32'h7);
    checks++;
    if (dout !== 32'h0) $display("FAIL rstw_dout actual=%h required=%h", dout, 32'h0);
    else passed++;
    cycle(1'b0, 1'b1, 1'b0, 8'h03, 32'h0);
    checks++;
    if (dout !== 32'h0) $display("FAIL rstw_mem3 actual=%h required=%h", dout, 32'h0);
    else passed++;
    cycle(1'b0, 1'b1, 1'b0, 8'hFF, 32'h0);
    checks++;
    if (dout !== 32'h0) $display("FAIL rstw_memff actual=%h required=%h", dout, 32'h0);
    else passed++;
    cycle(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
    checks++;
    if (dout !== 32'h0) $display("FAIL rstw_mem10 actual=%h required=%h", dout, 32'h0);
    else passed++;
  endtask

  task automatic test_random();
    logic       r, c, w;
    logic [7:0] a;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      // Narrow address window so reads frequently hit written words
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      cycle(r, c, w, a, 32'($urandom));
      checks++;
      if (dout !== model_dout)
        $display("FAIL random[%0d] addr=%h actual=%h required=%h", n, a, dout, model_dout);
      else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst  = 1'b0;
    cen  = 1'b0;
    wen  = 1'b0;
    addr = 8'h00;
    din  = 32'h0;
    model_dout = 32'h0;
    test_reset();
    test_write_read();
    test_cen_drop();
    test_boundary();
    test_back_to_back();
    test_reset_during_write();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
